// File: rtl/serial_framer_pkg.sv
// Shared types and constants for the serial framer.
// SERIAL_FRAMER_PARITY_EN adds the PARITY state to the enum.
package serial_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_FRAMER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Bit counter must hold 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_framer_if.sv
// Payload handshake between a producer and the serial framer.
interface serial_framer_if #(
  parameter int DATA_W = 8
);
  import serial_framer_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface

// File: rtl/serial_framer_hold.sv
// One-entry payload holding register; refillable while the framer shifts.
module serial_framer_hold
  import serial_framer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              take,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_full
);

  // take is only raised while full and a transfer only lands while empty,
  // so the two never collide in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (hold_full) begin
      if (take) hold_full <= 1'b0;
    end else if (data_valid) begin
      hold_full <= 1'b1;
      hold_data <= data_in;
    end
  end

  assign data_ready = !hold_full;

endmodule

// File: rtl/serial_framer.sv
// Serial framer: start bit, DATA_W payload bits, optional parity, STOP_BITS stop bits.
// Define SERIAL_FRAMER_PARITY_EN to add the parity bit and the PARITY_ODD parameter.
module serial_framer
  import serial_framer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0
`ifdef SERIAL_FRAMER_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sr_clk,
  input  logic           enable,
  input  logic           finish,
  serial_framer_if.slave bus,
  output logic           data_out,
  output logic           busy,
  output logic           frame_done
);

  localparam int CW = cnt_w(DATA_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              take;
  logic              tick;
  logic              line_d;
  logic              done_d;
`ifdef SERIAL_FRAMER_PARITY_EN
  logic              par_q, par_d;
`endif

  serial_framer_hold #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .data_in    (bus.data_in),
    .data_valid (bus.data_valid),
    .data_ready (bus.data_ready),
    .take       (take),
    .hold_data  (hold_data),
    .hold_full  (hold_full)
  );

  // Strobes that arrive while disabled or frozen are dropped, not queued.
  assign tick = sr_clk & enable & ~finish;
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    take    = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_FRAMER_PARITY_EN
    par_d   = par_q;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hold_full) begin
            state_d = START;
            take    = 1'b1;
          end
        end
        START: begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef SERIAL_FRAMER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0}
                                     : {1'b0, sh_q[DATA_W-1:1]};
          end
        end
`ifdef SERIAL_FRAMER_PARITY_EN
        PARITY: begin
          state_d = STOP;
          cnt_d   = '0;
        end
`endif
        STOP: begin
          if (cnt_q == CW'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // Chain straight into the next start bit when a payload is waiting.
            if (hold_full) begin
              state_d = START;
              take    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (take) begin
      sh_d = hold_data;
`ifdef SERIAL_FRAMER_PARITY_EN
      par_d = (^hold_data) ^ (PARITY_ODD != 0);
`endif
    end

    // Line level is a function of the next state, so data_out stays registered.
    line_d = IDLE_LEVEL;
    case (state_d)
      START:   line_d = START_LEVEL;
      DATA:    line_d = (MSB_FIRST != 0) ? sh_d[DATA_W-1] : sh_d[0];
`ifdef SERIAL_FRAMER_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      default: line_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      data_out   <= IDLE_LEVEL;
      frame_done <= 1'b0;
`ifdef SERIAL_FRAMER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      data_out   <= line_d;
      frame_done <= done_d;
`ifdef SERIAL_FRAMER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_framer.sv
// Directed bench for serial_framer: u0 is 8-bit LSB-first 1 stop, u1 is 8-bit MSB-first 2 stop.
module tb_serial_framer;

`ifdef SERIAL_FRAMER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk, reset, sr_clk, enable, finish;
  logic dout0, busy0, fd0, dout1, busy1, fd1;
  int   vec, miss, fd0_cnt, fd1_cnt, ph;

  serial_framer_if #(.DATA_W(8)) bus0 ();
  serial_framer_if #(.DATA_W(8)) bus1 ();

  serial_framer #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(0)
`ifdef SERIAL_FRAMER_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) u0 (
    .clk(clk), .reset(reset), .sr_clk(sr_clk), .enable(enable), .finish(finish),
    .bus(bus0), .data_out(dout0), .busy(busy0), .frame_done(fd0)
  );

  serial_framer #(.DATA_W(8), .STOP_BITS(2), .MSB_FIRST(1)
`ifdef SERIAL_FRAMER_PARITY_EN
    , .PARITY_ODD(1)
`endif
  ) u1 (
    .clk(clk), .reset(reset), .sr_clk(sr_clk), .enable(enable), .finish(finish),
    .bus(bus1), .data_out(dout1), .busy(busy1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit strobe on every 4th cycle.
  initial begin
    sr_clk = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 4;
      sr_clk = (ph == 0);
    end
  end

  always @(negedge clk) begin
    if (fd0) fd0_cnt++;
    if (fd1) fd1_cnt++;
  end

  // Sample the line after each qualified strobe; first sampled bit ends up leftmost.
  task automatic grab(input int inst, input int n, output logic [31:0] cap, output bit ok);
    int t;
    logic b;
    cap = '0;
    ok  = 1'b1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin
        @(posedge clk);
        t++;
      end while (!(sr_clk && enable && !finish) && t < 100);
      if (t >= 100) ok = 1'b0;
      @(negedge clk);
      b = (inst == 0) ? dout0 : dout1;
      cap = {cap[30:0], b};
    end
  endtask

  task automatic offer(input int inst, input logic [7:0] d, output bit ok);
    logic r;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = (inst == 0) ? bus0.data_ready : bus1.data_ready;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (inst == 0) begin bus0.data_in = d; bus0.data_valid = 1'b1; end
    else           begin bus1.data_in = d; bus1.data_valid = 1'b1; end
    @(posedge clk); #1;
    bus0.data_valid = 1'b0;
    bus1.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec++;
    if ({dout0, bus0.data_ready, busy0, fd0} !== 4'b1100) begin
      miss++; $display("FAIL reset_u0: got %b expected 1100", {dout0, bus0.data_ready, busy0, fd0});
    end
    vec++;
    if ({dout1, bus1.data_ready, busy1, fd1} !== 4'b1100) begin
      miss++; $display("FAIL reset_u1: got %b expected 1100", {dout1, bus1.data_ready, busy1, fd1});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lsb_frame();
    logic [31:0] cap, exp;
    bit ok;
    int fdb;
    fdb = fd0_cnt;
    offer(0, 8'hA5, ok);
    vec++;
    if (ok !== 1'b1) begin miss++; $display("FAIL lsb_offer: got %b expected 1", ok); end
    grab(0, 11 + PB, cap, ok);
`ifdef SERIAL_FRAMER_PARITY_EN
    exp = 32'b0_10100101_0_1_1;
`else
    exp = 32'b0_10100101_1_1;
`endif
    vec++;
    if (!ok || cap !== exp) begin miss++; $display("FAIL lsb_line: got %b expected %b", cap, exp); end
    @(negedge clk);
    vec++;
    if (busy0 !== 1'b0) begin miss++; $display("FAIL lsb_busy_end: got %b expected 0", busy0); end
    vec++;
    if (fd0_cnt - fdb !== 1) begin miss++; $display("FAIL lsb_frame_done: got %0d expected 1", fd0_cnt - fdb); end
  endtask

  task automatic test_msb_stop2();
    logic [31:0] cap, exp;
    bit ok;
    int fdb;
    fdb = fd1_cnt;
    offer(1, 8'hA5, ok);
    vec++;
    if (ok !== 1'b1) begin miss++; $display("FAIL msb_offer: got %b expected 1", ok); end
    grab(1, 11 + PB, cap, ok);
`ifdef SERIAL_FRAMER_PARITY_EN
    exp = 32'b0_10100101_1_11;
`else
    exp = 32'b0_10100101_11;
`endif
    vec++;
    if (!ok || cap !== exp) begin miss++; $display("FAIL msb_a5_line: got %b expected %b", cap, exp); end
    vec++;
    if (busy1 !== 1'b1) begin miss++; $display("FAIL msb_busy_stop2: got %b expected 1", busy1); end
    grab(1, 1, cap, ok);
    vec++;
    if (!ok || cap !== 32'b1 || busy1 !== 1'b0) begin
      miss++; $display("FAIL msb_idle: got line %b busy %b expected 1 0", cap[0], busy1);
    end
    @(negedge clk);
    vec++;
    if (fd1_cnt - fdb !== 1) begin miss++; $display("FAIL msb_frame_done: got %0d expected 1", fd1_cnt - fdb); end

    offer(1, 8'h96, ok);
    grab(1, 12 + PB, cap, ok);
`ifdef SERIAL_FRAMER_PARITY_EN
    exp = 32'b0_10010110_1_11_1;
`else
    exp = 32'b0_10010110_11_1;
`endif
    vec++;
    if (!ok || cap !== exp) begin miss++; $display("FAIL msb_96_line: got %b expected %b", cap, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap, exp;
    bit ok, okb;
    int fdb;
    fdb = fd0_cnt;
    offer(0, 8'h3C, ok);
    // Keep offering the second payload; it must not overwrite the first.
    bus0.data_in = 8'hC3;
    bus0.data_valid = 1'b1;
    @(negedge clk);
    vec++;
    if (bus0.data_ready !== 1'b0) begin miss++; $display("FAIL b2b_ready_drop: got %b expected 0", bus0.data_ready); end
    fork
      grab(0, 21 + 2 * PB, cap, ok);
      begin
        okb = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus0.data_ready) begin okb = 1'b1; break; end
        end
        vec++;
        if (!okb || busy0 !== 1'b1) begin
          miss++; $display("FAIL b2b_ready_while_busy: got ready %b busy %b expected 1 1", okb, busy0);
        end
        @(posedge clk); #1;
        bus0.data_valid = 1'b0;
      end
    join
`ifdef SERIAL_FRAMER_PARITY_EN
    exp = 32'b0_00111100_0_1_0_11000011_0_1_1;
`else
    exp = 32'b0_00111100_1_0_11000011_1_1;
`endif
    vec++;
    if (!ok || cap !== exp) begin miss++; $display("FAIL b2b_line: got %b expected %b", cap, exp); end
    @(negedge clk);
    vec++;
    if (fd0_cnt - fdb !== 2) begin miss++; $display("FAIL b2b_frame_done: got %0d expected 2", fd0_cnt - fdb); end
  endtask

  task automatic test_freeze();
    logic [31:0] cap, exp;
    bit ok, held;
    int fdb;
    fdb = fd0_cnt;
    offer(0, 8'h96, ok);
    grab(0, 5, cap, ok);
    vec++;
    if (!ok || cap !== 32'b0_0110) begin miss++; $display("FAIL freeze_pre: got %b expected 00110", cap); end
    held = 1'b1;
    finish = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dout0 !== 1'b0 || busy0 !== 1'b1) held = 1'b0;
    end
    finish = 1'b0;
    vec++;
    if (held !== 1'b1) begin miss++; $display("FAIL freeze_hold: got %b expected 1", held); end
    grab(0, 6 + PB, cap, ok);
`ifdef SERIAL_FRAMER_PARITY_EN
    exp = 32'b1001_0_1_1;
`else
    exp = 32'b1001_1_1;
`endif
    vec++;
    if (!ok || cap !== exp) begin miss++; $display("FAIL freeze_resume: got %b expected %b", cap, exp); end
    @(negedge clk);
    vec++;
    if (fd0_cnt - fdb !== 1) begin miss++; $display("FAIL freeze_frame_done: got %0d expected 1", fd0_cnt - fdb); end
  endtask

`ifdef SERIAL_FRAMER_PARITY_EN
  task automatic test_parity();
    logic [31:0] cap;
    bit ok;
    offer(0, 8'h07, ok);
    grab(0, 12, cap, ok);
    vec++;
    if (!ok || cap !== 32'b0_11100000_1_1_1) begin
      miss++; $display("FAIL parity_even: got %b expected 011100000111", cap);
    end
    offer(1, 8'h07, ok);
    grab(1, 13, cap, ok);
    vec++;
    if (!ok || cap !== 32'b0_00000111_0_11_1) begin
      miss++; $display("FAIL parity_odd: got %b expected 0000001110111", cap);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] cap;
    bit ok, okb;
    int fdb;
    offer(0, 8'h00, ok);
    fork
      grab(0, 7, cap, ok);
      offer(0, 8'h55, okb);
    join
    vec++;
    if (!ok || !okb || bus0.data_ready !== 1'b0 || dout0 !== 1'b0) begin
      miss++; $display("FAIL rstmid_setup: got ready %b line %b expected 0 0", bus0.data_ready, dout0);
    end
    fdb = fd0_cnt;
    reset = 1'b0;
    #1;
    vec++;
    if ({dout0, busy0, bus0.data_ready} !== 3'b101) begin
      miss++; $display("FAIL rstmid_async: got %b expected 101", {dout0, busy0, bus0.data_ready});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    grab(0, 3, cap, ok);
    vec++;
    if (!ok || cap !== 32'b111) begin miss++; $display("FAIL rstmid_no_frame: got %b expected 111", cap); end
    @(negedge clk);
    vec++;
    if ({busy0, bus0.data_ready} !== 2'b01 || fd0_cnt != fdb) begin
      miss++; $display("FAIL rstmid_idle: got busy/ready %b done %0d expected 01 0",
                       {busy0, bus0.data_ready}, fd0_cnt - fdb);
    end
  endtask

  initial begin
    vec = 0; miss = 0; fd0_cnt = 0; fd1_cnt = 0;
    reset = 1'b0; enable = 1'b1; finish = 1'b0;
    bus0.data_in = '0; bus0.data_valid = 1'b0;
    bus1.data_in = '0; bus1.data_valid = 1'b0;
    test_reset();
    test_lsb_frame();
    test_msb_stop2();
    test_back_to_back();
    test_freeze();
`ifdef SERIAL_FRAMER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/serial_framer.md
SERIAL_FRAMER -- requirements
Module: serial_framer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal 5..16).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-003 The block SHALL have parameter MSB_FIRST, default 0, meaning payload bit order (0 = LSB first).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sr_clk  input  1  bit-rate strobe, one clk cycle wide; each strobe advances the line by one bit.
REQ-007 enable  input  1  line-advance qualifier; a bit advances only when sr_clk & enable & !finish.
REQ-008 finish  input  1  freeze; while high, no bit advances, and state and data_out are held.
REQ-009 data_in  input  DATA_W  parallel payload.
REQ-010 data_valid  input  1  payload offer.
REQ-011 data_ready  output  1  high when the holding register is empty.
REQ-012 data_out  output  1  registered serial line.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse on the advance that ends the last stop bit.

Function
REQ-015 A transfer SHALL occur on a clk edge where data_valid & data_ready; data_in is captured into the holding register, and data_ready drops the next cycle.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; transitions occur only on qualified advances ("tick").
REQ-017 IDLE: data_out = 1; on a tick with the holding register full, the FSM SHALL go to START, move the holding register into the shift register, and clear the holding register in the same cycle.
REQ-018 START: data_out = 0 for one tick, then go to DATA.
REQ-019 DATA: data_out SHALL present payload bits in MSB_FIRST order, one per tick, for exactly DATA_W ticks, using a counter of width $clog2(DATA_W+1).
REQ-020 After DATA, the FSM SHALL go to PARITY when the parity feature is compiled in, otherwise to STOP.
REQ-021 STOP: data_out = 1 for STOP_BITS ticks; frame_done SHALL pulse on the final tick.
REQ-022 On the final stop tick, the FSM SHALL go to START if the holding register is full (back-to-back frames with no idle bit), else to IDLE.
REQ-023 The holding register SHALL be refillable while a frame shifts, so data_ready may be high while busy.
REQ-024 A tick and a transfer in the same cycle with an empty holding register in IDLE SHALL NOT start a frame until the next tick.
REQ-025 While the holding register is full, data_in SHALL be ignored and the register SHALL NOT be overwritten.
REQ-026 sr_clk high while enable = 0 or finish = 1 SHALL be discarded, not deferred.

Reset
REQ-027 While reset = 0: FSM = IDLE, counters = 0, holding register empty, data_out = 1, data_ready = 1, busy = 0, frame_done = 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately, drive the line idle high and discard any held payload.

Configuration
REQ-029 Macro SERIAL_FRAMER_PARITY_EN: when defined, the PARITY state and parameter PARITY_ODD (default 0) SHALL exist; the parity bit is the XOR of the payload, inverted when PARITY_ODD = 1, and occupies one tick.
REQ-030 When SERIAL_FRAMER_PARITY_EN is undefined, the frame is start + DATA_W + STOP_BITS bits and PARITY_ODD SHALL NOT exist.

Structure
REQ-031 Package serial_framer_pkg SHALL hold the state enum, the IDLE_LEVEL = 1'b1 and START_LEVEL = 1'b0 constants, and the counter-width function.
REQ-032 The one-entry holding register with its valid/ready logic SHALL be the sub-module serial_framer_hold; the FSM and shifter live in serial_framer.

Verification
REQ-033 DATA_W = 8, LSB-first, sr_clk every 4th cycle, 0xA5 offered -> line 0,1,0,1,0,0,1,0,1,1 (start, data, stop), then frame_done once.
REQ-034 MSB_FIRST = 1, 0xA5 -> data bits 1,0,1,0,0,1,0,1; STOP_BITS = 2 -> two high bits before IDLE.
REQ-035 0x3C then 0xC3 offered back to back -> second start bit immediately follows the stop bit, and data_ready re-asserts after the first frame loads.
REQ-036 finish high for 10 cycles during data bit 3 -> line value held, and the frame resumes with bit 4 with no bit lost or duplicated.
REQ-037 Parity compiled in, PARITY_ODD = 0, 0x07 -> parity bit 1; PARITY_ODD = 1 -> parity bit 0.
REQ-038 reset low during data bit 5 with a payload held -> data_out = 1 asynchronously; after release, idle with data_ready = 1 and no frame sent.
